// File: rtl/shift_pkg.sv
// Shared constants and the operation record passed from the issue stage
// to the shift datapath (Shift_Signal / Shifter_32).
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_SRA    = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]    datain;
        logic [SHAMT_W-1:0] s;
        logic               right;
        logic               sra;
        logic [4:0]         rd;
    } shift_op_t;

endpackage

// File: rtl/shift_issue_stage_if.sv
// Upstream (instruction + operands) and downstream (shifter controls)
// handshake bundle of the shift issue stage. The stage uses the slave
// modport; whoever drives ops in and consumes them uses master.
interface shift_issue_stage_if;
    import shift_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_datain;
    logic [SHAMT_W-1:0] out_s;
    logic               out_right;
    logic               out_sra;
    logic [4:0]         out_rd;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, out_datain, out_s, out_right, out_sra, out_rd
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, out_datain, out_s, out_right, out_sra, out_rd
    );

endinterface

// File: rtl/shift_decode.sv
// Combinational decode of RV32I shift encodings into shifter controls.
// Non-shift encodings report is_shift_o=0; their op fields are don't-care.
module shift_decode
    import shift_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output shift_op_t       op_o,
    output logic            is_shift_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register-source fields and the upper rs2 bits play no part in a shift
    logic unused_bits;
    assign unused_bits = ^{instr_i[19:15], rs2_data_i[XLEN-1:SHAMT_W]};

    // Classify the encoding and build the shifter fields
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch
        op_o        = '0;
        is_shift_o  = 1'b0;
        op_o.datain = rs1_data_i;
        op_o.rd     = instr_i[11:7];
        if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
            op_o.s = (opcode == OPC_OP) ? rs2_data_i[SHAMT_W-1:0] : instr_i[24:20];
            if (funct3 == F3_SLL && funct7 == F7_BASE) begin
                is_shift_o = 1'b1;
            end else if (funct3 == F3_SR && funct7 == F7_BASE) begin
                is_shift_o = 1'b1;
                op_o.right = 1'b1;
            end else if (funct3 == F3_SR && funct7 == F7_SRA) begin
                is_shift_o = 1'b1;
                op_o.right = 1'b1;
                op_o.sra   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes shift instructions and presents them to the
// shifter from a 2-entry skid buffer (main + skid) so in_ready is a flop.
// Illegal encodings are consumed, flagged for one cycle and recorded.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    shift_issue_stage_if.slave bus,
    output logic               illegal,
    output logic [31:0]        illegal_instr,
    output logic [CNT_W-1:0]   shift_count
);

    shift_op_t        dec_op;
    logic             dec_is_shift;

    logic             main_valid_q, main_valid_d;
    shift_op_t        main_op_q, main_op_d;
    logic             skid_valid_q, skid_valid_d;
    shift_op_t        skid_op_q, skid_op_d;
    logic             in_ready_q, in_ready_d;
    logic             illegal_q, illegal_d;
    logic [31:0]      illegal_instr_q, illegal_instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             push;
    logic             drain;

    shift_decode u_decode (
        .instr_i    (bus.instr),
        .rs1_data_i (bus.rs1_data),
        .rs2_data_i (bus.rs2_data),
        .op_o       (dec_op),
        .is_shift_o (dec_is_shift)
    );

    // An op offered during flush is dropped, so it is never accepted
    assign accept = bus.in_valid & in_ready_q & ~flush;
    assign push   = accept & dec_is_shift;
    assign drain  = main_valid_q & bus.out_ready;

    // Skid buffer next state; skid is only ever filled while main is held
    always_comb begin
        main_valid_d = main_valid_q;
        main_op_d    = main_op_q;
        skid_valid_d = skid_valid_q;
        skid_op_d    = skid_op_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                // in_ready was low, so no new op can arrive this cycle
                main_op_d    = skid_op_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_op_d    = dec_op;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (push) begin
                skid_valid_d = 1'b1;
                skid_op_d    = dec_op;
            end
        end else if (push) begin
            main_valid_d = 1'b1;
            main_op_d    = dec_op;
        end
        in_ready_d = ~skid_valid_d;
    end

    // Illegal-op flag, captured word and issued-shift counter
    always_comb begin
        illegal_d       = accept & ~dec_is_shift;
        illegal_instr_d = illegal_d ? bus.instr : illegal_instr_q;
        cnt_d           = cnt_q + CNT_W'(drain);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: buffer payload is reset too, so out_* read zero after reset
            main_valid_q    <= 1'b0;
            main_op_q       <= '0;
            skid_valid_q    <= 1'b0;
            skid_op_q       <= '0;
            in_ready_q      <= 1'b1;
            illegal_q       <= 1'b0;
            illegal_instr_q <= '0;
            cnt_q           <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            main_valid_q    <= main_valid_d;
            main_op_q       <= main_op_d;
            skid_valid_q    <= skid_valid_d;
            skid_op_q       <= skid_op_d;
            in_ready_q      <= in_ready_d;
            illegal_q       <= illegal_d;
            illegal_instr_q <= illegal_instr_d;
            cnt_q           <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = main_valid_q;
    assign bus.out_datain = main_op_q.datain;
    assign bus.out_s      = main_op_q.s;
    assign bus.out_right  = main_op_q.right;
    assign bus.out_sra    = main_op_q.sra;
    assign bus.out_rd     = main_op_q.rd;

    assign illegal        = illegal_q;
    assign illegal_instr  = illegal_instr_q;
    assign shift_count    = cnt_q;

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Issue stage directly upstream of the shift datapath (Shift_Signal feeding Shifter_32).
- Accepts RV32I instructions with operands under a valid/ready handshake and decodes SLL/SRL/SRA/SLLI/SRLI/SRAI.
- Drives the shifter's s / datain / right / sra inputs from a 2-entry skid buffer, so in_ready is a registered signal.
- Flags non-shift encodings and counts issued shifts.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
SHAMT_W, 5, shift-amount width (log2 XLEN)
CNT_W, 32, width of issued-shift counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush of buffered ops
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept op
instr  in  32  RV32I instruction word
rs1_data  in  XLEN  operand to be shifted
rs2_data  in  XLEN  register shift amount source (R-type)
out_valid  out  1  op presented to shifter
out_ready  in  1  downstream accepts op
out_datain  out  XLEN  to Shift_Signal.datain
out_s  out  SHAMT_W  to Shift_Signal.s
out_right  out  1  1 = right shift
out_sra  out  1  1 = arithmetic right (only with out_right=1)
out_rd  out  5  destination register, instr[11:7]
illegal  out  1  one-cycle pulse: non-shift op consumed
illegal_instr  out  32  instr of last illegal op, held
shift_count  out  CNT_W  ops handed downstream, wraps

Behaviour:
- Reset (rst_n=0, asynchronous): both buffer entries invalid, out_valid=0, all out_* data=0, illegal=0, illegal_instr=0, shift_count=0. in_ready=1 from the first cycle after reset.
- Accept: in_valid & in_ready at a rising edge.
- Decode, opcode 0110011 (OP):
  - funct3=001, funct7=0000000 -> SLL
  - funct3=101, funct7=0000000 -> SRL
  - funct3=101, funct7=0100000 -> SRA
  - shamt = rs2_data[4:0]
- Decode, opcode 0010011 (OP-IMM):
  - funct3=001, instr[31:25]=0000000 -> SLLI
  - funct3=101, instr[31:25]=0000000 -> SRLI
  - funct3=101, instr[31:25]=0100000 -> SRAI
  - shamt = instr[24:20]
- Field mapping: SLL/SLLI -> right=0, sra=0. SRL/SRLI -> right=1, sra=0. SRA/SRAI -> right=1, sra=1. out_datain = rs1_data.
- Illegal ops:
  - Any other encoding is still accepted (consumes the handshake) but never enqueued.
  - illegal=1 in the following cycle; illegal_instr captures instr.
- Buffer:
  - Main entry drives out_*. The skid entry captures an accepted op when main is valid and out_ready=0.
  - in_ready = !skid_valid, registered.
  - When main drains (out_valid & out_ready), skid moves to main in the same edge.
  - Order is strictly preserved.
- Latency: op accepted at edge N -> out_valid=1 with its fields from edge N, sampled on edge N+1. Throughput is 1 op/cycle when out_ready=1.
- out_* fields are stable while out_valid=1 and out_ready=0.
- shift_count increments by 1 on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Flush:
  - Both entries invalidated at the edge. An in_valid in the flush cycle is dropped (no enqueue, no illegal pulse). A downstream handshake in the flush cycle still counts.
  - in_ready=1 in the next cycle.
- Simultaneous events:
  - Accept plus drain with main valid and skid empty: new op replaces main, skid stays empty.
  - Accept when both entries are empty: op goes to main.
- Reset mid-operation: all state cleared immediately, no pulse emitted.

Decomposition:
- Shared package shift_pkg holds:
  - opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011
  - F3_SLL=3'b001, F3_SR=3'b101, F7_BASE=7'b0000000, F7_SRA=7'b0100000
  - the shift_op_t struct {datain, s, right, sra, rd}
- One sub-module, shift_decode: combinational instr/operands -> shift_op_t plus is_shift. The top holds the skid buffer, flag logic and counter.

Test Plan:
- SRLI x5,x1,4 (instr 0x0040D293), rs1_data=0xFFFFFFFF, out_ready=1 -> next cycle out_valid=1, out_s=4, out_right=1, out_sra=0, out_rd=5; downstream shifter yields 0x0FFFFFFF; shift_count=1.
- SRA R-type (0x4020D1B3), rs1_data=0x80000000, rs2_data=0x0000003F -> out_s=31, out_right=1, out_sra=1; shifter yields 0xFFFFFFFF.
- SLL, then SRL, then SRAI back-to-back with out_ready=0 -> after two accepts in_ready=0; the third is held off until out_ready=1; the three ops emerge in order with unchanged fields; shift_count=3.
- ADD (0x002081B3) with in_valid=1 -> accepted, no out_valid, illegal=1 for one cycle, illegal_instr=0x002081B3, shift_count unchanged.
- Both entries full, assert flush for one cycle with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; no op or illegal pulse from the dropped input.
- Deassert rst_n asynchronously mid-transfer -> out_valid, illegal and shift_count go to 0 without waiting for a clock edge.
